// File: rtl/floppy_uart_rx.sv
// ---------------------------------------------------------------------------
// floppy_uart_rx
//   UART receiver (8N1, LSB first) for the floppy controller's debug console.
//   Serial bytes are deserialised into a show-ahead FIFO that a debug overlay
//   or a bench checker drains through a pop handshake.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per bit (minimum 8)
//   FIFO_AW       log2 of the FIFO depth
//
// Ports
//   clk        in   system clock
//   reset_n    in   synchronous reset, active low
//   rxd        in   serial input, idle high, asynchronous to clk
//   rd         in   pop the FIFO head; ignored when empty
//   data       out  FIFO head, valid while empty==0 (0 when empty)
//   empty      out  FIFO holds no bytes
//   count      out  number of bytes held (saturates at 2^FIFO_AW)
//   frame_err  out  one-cycle pulse when a stop bit is sampled 0
//   overrun    out  sticky: a byte was dropped because the FIFO was full
//   clr_err    in   clears overrun (a coincident new overrun wins)
//   state_dbg  out  current receiver state (IDLE=0 START=1 DATA=2 STOP=3 WAITHI=4)
//
// Handshake: the pop side is a valid/ready pair in disguise -- !empty is
// "valid" for data, rd is "ready"; a byte transfers on every clk edge where
// rd && !empty, and rd with empty==1 has no effect.
// ---------------------------------------------------------------------------
module floppy_uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_AW      = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               rxd,
  input  logic               rd,
  output logic [7:0]         data,
  output logic               empty,
  output logic [FIFO_AW:0]   count,
  output logic               frame_err,
  output logic               overrun,
  input  logic               clr_err,
  output logic [2:0]         state_dbg
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 2;
  localparam logic [CW-1:0]      HALF_LD  = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0]      BIT_LD   = CW'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0]   FULL_CNT = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
    S_WAITHI = 3'd4
  } state_t;

  state_t state, state_nx;

  // -------------------------------------------------------------------------
  // Input synchroniser plus two history taps for the majority vote.
  // All preset to 1 so reset never fabricates a start edge.
  // -------------------------------------------------------------------------
  logic rx_meta, rxs, rxs_d1, rxs_d2;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_d1  <= 1'b1;
      rxs_d2  <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
      rxs_d1  <= rxs;
      rxs_d2  <= rxs_d1;
    end
  end

  // Majority of the three most recent rxs values (c-1, c, c+1).
  logic maj;
  assign maj = (rxs_d2 & rxs_d1) | (rxs_d2 & rxs) | (rxs_d1 & rxs);

  // -------------------------------------------------------------------------
  // Bit timing: a down-counter that is reloaded at every sample point, so
  // consecutive sample points are exactly CLKS_PER_BIT cycles apart.
  // -------------------------------------------------------------------------
  logic [CW-1:0] bit_cnt;
  logic          tick;
  logic          cnt_load;
  logic [CW-1:0] cnt_ld_val;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          shift_en;
  logic          push;
  logic          fe_set;

  assign tick = (bit_cnt == '0);

  always_comb begin
    state_nx   = state;
    cnt_load   = 1'b0;
    cnt_ld_val = BIT_LD;
    shift_en   = 1'b0;
    push       = 1'b0;
    fe_set     = 1'b0;
    case (state)
      S_IDLE: begin
        if (rxs_d1 && !rxs) begin
          state_nx   = S_START;
          cnt_load   = 1'b1;
          cnt_ld_val = HALF_LD;
        end
      end
      S_START: begin
        if (tick) begin
          if (maj) begin
            state_nx = S_IDLE;          // false start
          end else begin
            state_nx = S_DATA;
            cnt_load = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_en = 1'b1;
          cnt_load = 1'b1;
          if (bit_idx == 3'd7) state_nx = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (maj) begin
            push     = 1'b1;
            state_nx = S_IDLE;
          end else begin
            fe_set   = 1'b1;
            state_nx = S_WAITHI;
          end
        end
      end
      S_WAITHI: begin
        if (rxs) state_nx = S_IDLE;     // hold through breaks
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      bit_idx   <= 3'd0;
      shreg     <= 8'd0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nx;
      frame_err <= fe_set;
      if (cnt_load)       bit_cnt <= cnt_ld_val;
      else if (!tick)     bit_cnt <= bit_cnt - CW'(1);
      if (state != S_DATA) bit_idx <= 3'd0;
      else if (shift_en)   bit_idx <= bit_idx + 3'd1;
      if (shift_en) shreg <= {maj, shreg[7:1]};   // LSB arrives first
    end
  end

  assign state_dbg = state;

  // -------------------------------------------------------------------------
  // Show-ahead FIFO. A pop on a full FIFO frees the slot the same-cycle push
  // uses, so push+pop while full is lossless.
  // -------------------------------------------------------------------------
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wptr, rptr;
  logic               full, do_pop, do_push, ovr_set;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = rd && !empty;
  assign do_push = push && (!full || do_pop);
  assign ovr_set = push && full && !do_pop;
  assign data    = empty ? 8'd0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= shreg;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (do_push) wptr <= wptr + FIFO_AW'(1);
      if (do_pop)  rptr <= rptr + FIFO_AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (FIFO_AW + 1)'(1);
        2'b01:   count <= count - (FIFO_AW + 1)'(1);
        default: count <= count;
      endcase
      if (ovr_set)      overrun <= 1'b1;
      else if (clr_err) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_floppy_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_floppy_uart_rx
//   Self-checking bench for floppy_uart_rx with CLKS_PER_BIT=8, FIFO_AW=2.
//   Frames are driven on rxd one negedge per cycle; a byte-level model
//   (expected queue, overrun flag, frame-error count) predicts the FIFO.
// ---------------------------------------------------------------------------
module tb_floppy_uart_rx;

  localparam int CPB   = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;
  localparam logic [2:0] ST_IDLE = 3'd0;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset_n;
  logic          rxd, rd, clr_err;
  logic [7:0]    data;
  logic          empty, frame_err, overrun;
  logic [AW:0]   count;
  logic [2:0]    state_dbg;

  always #5 clk = ~clk;

  floppy_uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rxd       (rxd),
    .rd        (rd),
    .data      (data),
    .empty     (empty),
    .count     (count),
    .frame_err (frame_err),
    .overrun   (overrun),
    .clr_err   (clr_err),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  logic       exp_ovr;
  int         fe_exp;
  int         fe_seen;
  int         n_checks;
  int         n_pass;

  always @(negedge clk) if (frame_err === 1'b1) fe_seen++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic check_fifo(input string tag);
    check({tag, ".empty"}, 32'(empty), 32'(exp_q.size() == 0));
    check({tag, ".count"}, 32'(count), 32'(exp_q.size()));
    if (exp_q.size() > 0) check({tag, ".data"}, 32'(data), 32'(exp_q[0]));
    check({tag, ".overrun"}, 32'(overrun), 32'(exp_ovr));
    check({tag, ".frame_err_cnt"}, 32'(fe_seen), 32'(fe_exp));
    check({tag, ".state"}, 32'(state_dbg), 32'(ST_IDLE));
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_ovr = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one 8N1 frame starting on the current negedge. rd_at_stop raises
  // rd for the clock edge on which the stop bit is decided; rst_bit >= 0
  // pulses reset_n low for one cycle in the middle of that bit; hold_low
  // keeps rxd low that many extra cycles after the stop bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_v,
                            input bit rd_at_stop, input int rst_bit,
                            input int hold_low);
    logic [9:0] bits;
    bits = {stop_v, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rxd = bits[k];
      for (int c = 0; c < CPB; c++) begin
        if (k == 9 && c == CPB - 1) begin
          check("pre_push_count", 32'(count), 32'(exp_q.size()));
          if (rd_at_stop) rd = 1'b1;
        end
        if (k == rst_bit && c == CPB / 2)     reset_n = 1'b0;
        if (k == rst_bit && c == CPB / 2 + 1) begin
          reset_n = 1'b1;
          model_reset();
        end
        @(negedge clk);
      end
    end
    rd = 1'b0;
    if (hold_low > 0) begin
      rxd = 1'b0;
      idle(hold_low);
    end
    rxd = 1'b1;
    if (rst_bit < 0) begin
      if (rd_at_stop && exp_q.size() > 0) void'(exp_q.pop_front());
      if (!stop_v) fe_exp++;
      else if (exp_q.size() < DEPTH) exp_q.push_back(b);
      else exp_ovr = 1'b1;
    end
  endtask

  task automatic pop();
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    exp_ovr = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #(60000 * 10);
    $display("FAIL watchdog simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] b;
    logic       stop_ok;
    bit         rd_stop;
    int         npop;

    n_checks = 0; n_pass = 0; fe_exp = 0; fe_seen = 0;
    exp_ovr  = 1'b0;
    reset_n  = 1'b0; rxd = 1'b1; rd = 1'b0; clr_err = 1'b0;
    idle(3);
    check("reset.data", 32'(data), 32'h0);
    check_fifo("reset");
    reset_n = 1'b1;
    idle(4);

    // 1: single byte, then pop
    send_frame(8'hA5, 1'b1, 1'b0, -1, 0);
    check_fifo("t1.rx");
    idle(4);
    pop();
    check_fifo("t1.pop");
    pop();                                   // rd while empty: no effect
    check_fifo("t1.pop_empty");

    // 2: short glitch is a false start
    rxd = 1'b0; idle(2); rxd = 1'b1;
    idle(16);
    check_fifo("t2.glitch");
    send_frame(8'h5A, 1'b1, 1'b0, -1, 0);
    idle(4);
    check_fifo("t2.rx");
    pop();

    // 3: bad stop bit followed by a long low, then a good frame
    send_frame(8'h3C, 1'b0, 1'b0, -1, 20);
    idle(6);
    check_fifo("t3.ferr");
    send_frame(8'h11, 1'b1, 1'b0, -1, 0);
    idle(4);
    check_fifo("t3.rx");
    pop();

    // 4: overfill
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1, 1'b0, -1, 0);
      idle(4);
    end
    check_fifo("t4.full");
    pulse_clr();
    check_fifo("t4.clr");

    // 5: pop on the push cycle while full
    send_frame(8'h06, 1'b1, 1'b1, -1, 0);
    idle(4);
    check_fifo("t5.swap");
    for (int i = 0; i < 4; i++) begin
      pop();
      check_fifo("t5.drain");
    end

    // 6: reset in the middle of bit 4
    send_frame(8'h44, 1'b1, 1'b0, -1, 0);
    idle(4);
    send_frame(8'hF3, 1'b1, 1'b0, 4, 0);
    idle(4);
    check_fifo("t6.reset");
    send_frame(8'h7E, 1'b1, 1'b0, -1, 0);
    idle(4);
    check_fifo("t6.rx");
    pop();

    // randomized frames, pops and clears
    for (int it = 0; it < 30; it++) begin
      b       = 8'($urandom_range(0, 255));
      stop_ok = ($urandom_range(0, 5) != 0);
      rd_stop = ($urandom_range(0, 3) == 0);
      send_frame(b, stop_ok, rd_stop, -1, stop_ok ? 0 : int'($urandom_range(0, 12)));
      idle(5);
      check_fifo("rnd.frame");
      npop = $urandom_range(0, 2);
      for (int p = 0; p < npop; p++) begin
        pop();
        check_fifo("rnd.pop");
      end
      if ($urandom_range(0, 3) == 0) begin
        pulse_clr();
        check_fifo("rnd.clr");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
